traffic_ctrl_multi: RTL and testbench

//  Parametrised successor to the single-junction traffic FSM. Drives one main/side junction and
//  N_PED pedestrian crossings. Phase timing is generated internally, so no external timer_done

---
 rtl/traffic_ctrl_multi.sv | 106 ++++++++++
 tb/tb_traffic_ctrl_multi.sv | 89 ++++++++
 2 files changed

// File: rtl/traffic_ctrl_multi.sv
// traffic_ctrl_multi: main/side junction plus N_PED pedestrian crossings with internal phase timing.
// Define EMERGENCY_PREEMPT_EN to add the emergency port and preemption behaviour.
module traffic_ctrl_multi #(
  parameter int N_PED        = 2,
  parameter int TIMER_W      = 8,
  parameter int MAIN_GREEN_T = 20,
  parameter int SIDE_GREEN_T = 10,
  parameter int WARN_T       = 3,
  parameter int PED_T        = 8,
  parameter int ALL_RED_T    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             side_request,
  input  logic [N_PED-1:0] ped_request,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic             emergency,
`endif
  output logic             main_green,
  output logic             side_green,
  output logic             warning,
  output logic             all_red,
  output logic [N_PED-1:0] ped_walk,
  output logic [N_PED-1:0] ped_pending,
  output logic [2:0]       phase
);
  localparam logic [2:0] S_MG = 3'd0, S_MW = 3'd1, S_AR = 3'd2, S_PW = 3'd3, S_SG = 3'd4, S_SW = 3'd5;
  localparam logic [TIMER_W-1:0] L_MG  = TIMER_W'(MAIN_GREEN_T - 1);
  localparam logic [TIMER_W-1:0] L_SG  = TIMER_W'(SIDE_GREEN_T - 1);
  localparam logic [TIMER_W-1:0] L_WN  = TIMER_W'(WARN_T - 1);
  localparam logic [TIMER_W-1:0] L_PW  = TIMER_W'(PED_T - 1);
  localparam logic [TIMER_W-1:0] L_AR  = TIMER_W'(ALL_RED_T - 1);
  localparam logic [TIMER_W-1:0] T_ONE = TIMER_W'(1);
  logic [2:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               side_pending_q, side_pending_d;
  logic [N_PED-1:0]   ped_pending_q, ped_pending_d;
  logic [N_PED-1:0]   walk_mask_q, walk_mask_d;
  logic               to_main_q, to_main_d;
  logic               expire, any_ped, enter, ped_enter, emg;
`ifdef EMERGENCY_PREEMPT_EN
  assign emg = emergency;
`else
  assign emg = 1'b0;
`endif
  always_comb begin
    expire    = timer_q == '0;
    any_ped   = |ped_pending_q;
    state_d   = state_q;
    to_main_d = to_main_q;
    case (state_q)
      S_MG: state_d = (expire && !emg && (side_pending_q || any_ped)) ? S_MW : S_MG;
      S_MW: if (expire) begin
        state_d   = S_AR;
        to_main_d = 1'b0;
      end
      S_AR: if (expire) state_d = (to_main_q || emg) ? S_MG : any_ped ? S_PW : S_SG;
      S_PW: if (emg) state_d = S_SW;
      else if (expire) begin
        state_d   = side_pending_q ? S_SG : S_AR;
        to_main_d = to_main_q | !side_pending_q;
      end
      S_SG: state_d = (emg || expire) ? S_SW : S_SG;
      S_SW: if (expire) begin
        state_d   = S_AR;
        to_main_d = 1'b1;
      end
      default: state_d = S_MG;
    endcase
    enter     = state_d != state_q;
    ped_enter = enter && state_d == S_PW;
    timer_d   = !enter ? (expire ? '0 : timer_q - T_ONE) :
                state_d == S_MG ? L_MG :
                state_d == S_SG ? L_SG :
                state_d == S_PW ? L_PW :
                state_d == S_AR ? L_AR : L_WN;
    // the vehicle that triggers side green is served, so same-cycle requests are dropped
    side_pending_d = (enter && state_d == S_SG) ? 1'b0 : side_pending_q | side_request;
    ped_pending_d  = ped_enter ? '0 : ped_pending_q | ped_request;
    walk_mask_d    = ped_enter ? ped_pending_q | ped_request : walk_mask_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_MG;
      timer_q        <= L_MG;
      side_pending_q <= 1'b0;
      ped_pending_q  <= '0;
      walk_mask_q    <= '0;
      to_main_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      side_pending_q <= side_pending_d;
      ped_pending_q  <= ped_pending_d;
      walk_mask_q    <= walk_mask_d;
      to_main_q      <= to_main_d;
    end
  end
  assign main_green  = state_q == S_MG;
  assign side_green  = state_q == S_SG;
  assign warning     = state_q == S_MW || state_q == S_SW;
  assign all_red     = state_q == S_AR;
  assign ped_walk    = state_q == S_PW ? walk_mask_q : '0;
  assign ped_pending = ped_pending_q;
  assign phase       = state_q;
endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// tb_traffic_ctrl_multi: directed scoreboard bench; stimulus queues expected lamp states, a negedge monitor checks them.
module tb_traffic_ctrl_multi;
  logic       clk = 1'b0, rst = 1'b0, side_request = 1'b0, emergency = 1'b0;
  logic [1:0] ped_request = 2'b00;
  logic       main_green, side_green, warning, all_red;
  logic [1:0] ped_walk, ped_pending;
  logic [2:0] phase;
  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] ph;
    logic [1:0] walk;
    logic [1:0] pend;
  } exp_t;
  exp_t  q[$];
  int    cyc = 0, vectors = 0, miscompares = 0;
  string tname = "";
  traffic_ctrl_multi #(
    .N_PED(2), .TIMER_W(8), .MAIN_GREEN_T(4), .SIDE_GREEN_T(3), .WARN_T(2), .PED_T(3), .ALL_RED_T(1)
  ) dut (
    .clk(clk), .rst(rst), .side_request(side_request), .ped_request(ped_request),
`ifdef EMERGENCY_PREEMPT_EN
    .emergency(emergency),
`endif
    .main_green(main_green), .side_green(side_green), .warning(warning), .all_red(all_red),
    .ped_walk(ped_walk), .ped_pending(ped_pending), .phase(phase)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [10:0] got, want;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e    = q.pop_front();
      want = {e.ph == 3'd0, e.ph == 3'd4, e.ph == 3'd1 || e.ph == 3'd5, e.ph == 3'd2, e.walk, e.pend, e.ph};
      got  = {main_green, side_green, warning, all_red, ped_walk, ped_pending, phase};
      vectors++;
      if (e.cyc != cyc || got !== want) begin
        miscompares++;
        $display("FAIL %s cyc %0d (due %0d): got mg,sg,wn,ar,walk,pend,ph=%b want %b", e.name, cyc, e.cyc, got, want);
      end
    end
  end
  task automatic step(input logic r, input logic s, input logic [1:0] p,
                      input logic [2:0] ph, input logic [1:0] w, input logic [1:0] pd);
    rst = r; side_request = s; ped_request = p;
    q.push_back('{cyc + 1, tname, ph, w, pd});
    @(negedge clk);
  endtask
  task automatic run(input int n, input logic [2:0] ph, input logic [1:0] w, input logic [1:0] pd);
    repeat (n) step(1'b1, 1'b0, 2'b00, ph, w, pd);
  endtask
  task automatic do_reset;
    step(1'b0, 1'b0, 2'b00, 3'd0, 2'b00, 2'b00);
  endtask
  initial begin
    @(negedge clk);
    tname = "idle";
    do_reset; run(30, 0, 0, 0);
    tname = "side";
    do_reset; run(1, 0, 0, 0); step(1, 1, 2'b00, 0, 0, 0); run(1, 0, 0, 0);
    run(2, 1, 0, 0); run(1, 2, 0, 0); run(3, 4, 0, 0); run(2, 5, 0, 0); run(1, 2, 0, 0); run(3, 0, 0, 0);
    tname = "ped10";
    do_reset; step(1, 0, 2'b10, 0, 0, 2'b10); run(2, 0, 0, 2'b10); run(2, 1, 0, 2'b10); run(1, 2, 0, 2'b10);
    run(3, 3, 2'b10, 0); run(1, 2, 0, 0); run(3, 0, 0, 0);
    tname = "ped01_side";
    do_reset; step(1, 1, 2'b01, 0, 0, 2'b01); run(2, 0, 0, 2'b01); run(2, 1, 0, 2'b01); run(1, 2, 0, 2'b01);
    run(3, 3, 2'b01, 0); run(3, 4, 0, 0); run(2, 5, 0, 0); run(1, 2, 0, 0); run(2, 0, 0, 0);
    tname = "rst_mid";
    do_reset; step(1, 1, 2'b00, 0, 0, 0); run(2, 0, 0, 0); run(2, 1, 0, 0); run(1, 2, 0, 0); run(1, 4, 0, 0);
    step(1, 0, 2'b11, 4, 0, 2'b11); step(0, 0, 2'b00, 0, 0, 0); run(2, 0, 0, 0);
`ifdef EMERGENCY_PREEMPT_EN
    tname = "emergency";
    do_reset; step(1, 1, 2'b00, 0, 0, 0); run(2, 0, 0, 0); run(2, 1, 0, 0); run(1, 2, 0, 0); run(1, 4, 0, 0);
    emergency = 1'b1;
    run(2, 5, 0, 0); run(1, 2, 0, 0); run(1, 0, 0, 0); step(1, 0, 2'b01, 0, 0, 2'b01); run(5, 0, 0, 2'b01);
    emergency = 1'b0;
    run(2, 1, 0, 2'b01); run(1, 2, 0, 2'b01); run(3, 3, 2'b01, 0); run(1, 2, 0, 0); run(1, 0, 0, 0);
`endif
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d unchecked expectations want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
